ahb_slave_split: RTL and testbench

- Second-generation AHB slave front-end for the AHB-to-APB bridge.
- Accepts AHB reads and writes and checks transfer legality.
- Issues one or more narrow backend beats to the APB master side over a req/ack handshake, splitting AHB transfers wider than the APB data path.
- Returns assembled read data, wait states and the two-cycle AHB ERROR response.

---
 rtl/ahb_slave_split.sv | 246 ++++++++++++++++++++++++
 tb/tb_ahb_slave_split.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_split.sv
// ---------------------------------------------------------------------------
// ahb_slave_split
//
// AHB slave front-end for the AHB-to-APB bridge. It accepts AHB transfers,
// rejects illegal ones with the two-cycle ERROR response, and splits each legal
// transfer into one or more narrow backend beats on a req/ack handshake. Read
// beats are assembled into an AHB-wide word that is presented on o_HRDATA.
//
// Ports
//   HCLK, HRESET        clock, synchronous active-high reset
//   i_HSEL .. i_HREADY  AHB address/data phase inputs
//   o_HREADYOUT, o_HRESP, o_HRDATA
//                       AHB slave response
//   o_req, o_req_addr, o_req_write, o_req_size, o_req_wdata
//                       backend beat request (held until i_ack)
//   i_ack, i_ack_rdata, i_ack_err
//                       backend beat completion, read data and error
// ---------------------------------------------------------------------------
module ahb_slave_split #(
    parameter int AHB_AW = 32,
    parameter int AHB_DW = 32,
    parameter int APB_DW = 8
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              i_HSEL,
    input  logic [AHB_AW-1:0] i_HADDR,
    input  logic [1:0]        i_HTRANS,
    input  logic              i_HWRITE,
    input  logic [2:0]        i_HSIZE,
    input  logic [AHB_DW-1:0] i_HWDATA,
    input  logic              i_HREADY,
    output logic              o_HREADYOUT,
    output logic              o_HRESP,
    output logic [AHB_DW-1:0] o_HRDATA,
    output logic              o_req,
    output logic [AHB_AW-1:0] o_req_addr,
    output logic              o_req_write,
    output logic [2:0]        o_req_size,
    output logic [APB_DW-1:0] o_req_wdata,
    input  logic              i_ack,
    input  logic [APB_DW-1:0] i_ack_rdata,
    input  logic              i_ack_err
);

    localparam int AB     = AHB_DW / 8;
    localparam int PB     = APB_DW / 8;
    localparam int AB_LOG = $clog2(AB);
    localparam int PB_LOG = $clog2(PB);
    localparam int NL     = AB / PB;        // APB lanes across the AHB bus
    localparam int CW     = AB_LOG + 1;     // beat counter width

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WDATA = 3'd1,
        S_REQ   = 3'd2,
        S_ERR1  = 3'd3,
        S_ERR2  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [AHB_AW-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic              write_q, write_d;
    logic [AHB_DW-1:0] wdata_q, wdata_d;
    logic [AHB_DW-1:0] acc_q, acc_d;
    logic [AHB_DW-1:0] hrdata_q, hrdata_d;
    logic [CW-1:0]     beat_q, beat_d;

    logic              hreadyout;
    logic              hresp;
    logic              req;
    logic              valid;
    logic              illegal;
    logic [6:0]        align_mask;
    logic [CW-1:0]     last_beat;
    logic [AHB_AW-1:0] beat_addr;
    logic [AB_LOG-1:0] lane_idx;
    logic [AHB_DW-1:0] acc_merged;
    logic [APB_DW-1:0] req_wdata;
    logic              beat_done;

    // -----------------------------------------------------------------------
    // Transfer qualification
    // -----------------------------------------------------------------------
    assign valid      = i_HSEL & i_HREADY & i_HTRANS[1] & hreadyout;
    assign align_mask = 7'((8'd1 << i_HSIZE) - 8'd1);
    assign illegal    = (i_HSIZE > 3'(AB_LOG)) || (|(i_HADDR[6:0] & align_mask));

    // -----------------------------------------------------------------------
    // Beat geometry: beat k sits at base + k*PB; its lane is the PB-aligned
    // byte offset of that address within the AHB bus.
    // -----------------------------------------------------------------------
    always_comb begin
        last_beat = '0;
        if (size_q > 3'(PB_LOG)) begin
            last_beat = CW'((32'd1 << (size_q - 3'(PB_LOG))) - 32'd1);
        end
    end

    assign beat_addr = addr_q + (AHB_AW'(beat_q) << PB_LOG);
    assign lane_idx  = beat_addr[AB_LOG-1:0] >> PB_LOG;
    assign beat_done = req & i_ack;

    always_comb begin
        req_wdata = '0;
        for (int i = 0; i < NL; i++) begin
            if (lane_idx == AB_LOG'(i)) begin
                req_wdata = wdata_q[i*APB_DW +: APB_DW];
            end
        end
    end

    // Accumulator with the current beat's read data dropped into its lane
    genvar gi;
    generate
        for (gi = 0; gi < NL; gi++) begin : g_lane
            assign acc_merged[gi*APB_DW +: APB_DW] =
                (lane_idx == AB_LOG'(gi)) ? i_ack_rdata : acc_q[gi*APB_DW +: APB_DW];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            acc_q    <= '0;
            hrdata_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            acc_q    <= acc_d;
            hrdata_q <= hrdata_d;
            beat_q   <= beat_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        acc_d    = acc_q;
        hrdata_d = hrdata_q;
        beat_d   = beat_q;

        case (state_q)
            S_IDLE, S_ERR2: begin
                // ERR2 already drives HREADYOUT=1, so it can take a new
                // transfer exactly like IDLE does.
                state_d = S_IDLE;
                if (valid) begin
                    addr_d  = i_HADDR;
                    size_d  = i_HSIZE;
                    write_d = i_HWRITE;
                    acc_d   = '0;
                    beat_d  = '0;
                    if (illegal) begin
                        state_d = S_ERR1;
                    end else if (i_HWRITE) begin
                        state_d = S_WDATA;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end

            S_WDATA: begin
                wdata_d = i_HWDATA;
                state_d = S_REQ;
            end

            S_REQ: begin
                if (beat_done) begin
                    if (!write_q) begin
                        acc_d = acc_merged;
                    end
                    if (i_ack_err) begin
                        state_d = S_ERR1;
                    end else if (beat_q == last_beat) begin
                        state_d = S_IDLE;
                        if (!write_q) begin
                            hrdata_d = acc_merged;
                        end
                    end else begin
                        beat_d = beat_q + CW'(1);
                    end
                end
            end

            S_ERR1: begin
                state_d = S_ERR2;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        req       = 1'b0;
        case (state_q)
            S_WDATA: hreadyout = 1'b0;
            S_REQ: begin
                hreadyout = 1'b0;
                req       = 1'b1;
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            S_ERR2:  hresp = 1'b1;
            default: ;
        endcase
    end

    assign o_HREADYOUT = hreadyout;
    assign o_HRESP     = hresp;
    assign o_HRDATA    = hrdata_q;
    assign o_req       = req;
    assign o_req_addr  = beat_addr;
    assign o_req_write = write_q;
    assign o_req_size  = (size_q > 3'(PB_LOG)) ? 3'(PB_LOG) : size_q;
    assign o_req_wdata = req_wdata;

endmodule

// File: tb/tb_ahb_slave_split.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_split
//
// Directed scenarios followed by randomized transfers for ahb_slave_split.
// A reference model computes the expected beats, wait states, response and
// assembled read data from the transfer rules; a byte memory supplies the
// backend read data.
// ---------------------------------------------------------------------------
module tb_ahb_slave_split;

    localparam int AHB_AW = 32;
    localparam int AHB_DW = 32;
    localparam int APB_DW = 8;
    localparam int AB     = AHB_DW / 8;
    localparam int PB     = APB_DW / 8;
    localparam int PB_LOG = $clog2(PB);

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic              i_HSEL;
    logic [AHB_AW-1:0] i_HADDR;
    logic [1:0]        i_HTRANS;
    logic              i_HWRITE;
    logic [2:0]        i_HSIZE;
    logic [AHB_DW-1:0] i_HWDATA;
    logic              i_HREADY;
    logic              o_HREADYOUT;
    logic              o_HRESP;
    logic [AHB_DW-1:0] o_HRDATA;
    logic              o_req;
    logic [AHB_AW-1:0] o_req_addr;
    logic              o_req_write;
    logic [2:0]        o_req_size;
    logic [APB_DW-1:0] o_req_wdata;
    logic              i_ack;
    logic [APB_DW-1:0] i_ack_rdata;
    logic              i_ack_err;

    ahb_slave_split #(
        .AHB_AW(AHB_AW),
        .AHB_DW(AHB_DW),
        .APB_DW(APB_DW)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .i_HSEL     (i_HSEL),
        .i_HADDR    (i_HADDR),
        .i_HTRANS   (i_HTRANS),
        .i_HWRITE   (i_HWRITE),
        .i_HSIZE    (i_HSIZE),
        .i_HWDATA   (i_HWDATA),
        .i_HREADY   (i_HREADY),
        .o_HREADYOUT(o_HREADYOUT),
        .o_HRESP    (o_HRESP),
        .o_HRDATA   (o_HRDATA),
        .o_req      (o_req),
        .o_req_addr (o_req_addr),
        .o_req_write(o_req_write),
        .o_req_size (o_req_size),
        .o_req_wdata(o_req_wdata),
        .i_ack      (i_ack),
        .i_ack_rdata(i_ack_rdata),
        .i_ack_err  (i_ack_err)
    );

    always #5 HCLK = ~HCLK;

    int                n_checks = 0;
    int                n_pass   = 0;
    int                n_fail   = 0;
    logic [7:0]        mem [0:4095];
    logic [AHB_DW-1:0] model_hrdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One AHB transfer from address phase to completion. Called at a negedge
    // with the slave ready; returns at the negedge where HREADYOUT is high
    // again (IDLE, or ERR2 for an error), so a follow-up transfer can be
    // presented straight away.
    task automatic xfer(input string tag, input logic [31:0] a, input logic [2:0] sz,
                        input logic wr, input logic [31:0] wd, input int err_beat,
                        input int stall_pct);
        int                n, n_issue, k, waits, stalls, exp_waits;
        bit                illegal, beat_err, done, saw_err1;
        logic [31:0]       ak, base_k;
        logic [AHB_DW-1:0] exp_rd;
        logic [APB_DW-1:0] exp_wd;

        illegal  = (sz > 3'd2) || ((a % (32'd1 << sz)) != 0);
        n        = ((1 << sz) > PB) ? ((1 << sz) / PB) : 1;
        beat_err = !illegal && (err_beat >= 0) && (err_beat < n);
        n_issue  = illegal ? 0 : (beat_err ? err_beat + 1 : n);
        exp_rd   = '0;

        chk({tag, " ready"}, o_HREADYOUT, 1);
        i_HSEL   = 1'b1;
        i_HTRANS = 2'd2;
        i_HADDR  = a;
        i_HSIZE  = sz;
        i_HWRITE = wr;
        i_HREADY = 1'b1;
        @(negedge HCLK);
        i_HWDATA = wd;

        k = 0; waits = 0; stalls = 0; done = 0; saw_err1 = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (cyc == 0) chk({tag, " first_req"}, o_req, (!illegal && !wr));
            if (o_HREADYOUT) begin
                done      = 1;
                i_HSEL    = 1'b0;
                i_HTRANS  = 2'd0;
                i_HREADY  = 1'b1;
                i_ack     = 1'b0;
                i_ack_err = 1'b0;
            end else begin
                waits++;
                // Bus activity while the slave stalls must be ignored
                i_HSEL      = 1'b1;
                i_HTRANS    = 2'($urandom_range(3));
                i_HADDR     = $urandom;
                i_HSIZE     = 3'($urandom_range(7));
                i_HWRITE    = 1'($urandom_range(1));
                i_HREADY    = 1'($urandom_range(1));
                i_ack       = 1'b0;
                i_ack_err   = 1'b0;
                i_ack_rdata = APB_DW'($urandom);
                if (o_HRESP) begin
                    saw_err1 = 1;
                end else if (o_req) begin
                    if (k >= n_issue) begin
                        chk({tag, " beat_count"}, k, n_issue);
                    end else begin
                        ak     = (n == 1) ? a : a + k * PB;
                        base_k = ak & ~(PB - 1);
                        exp_wd = APB_DW'(wd >> (8 * (base_k % AB)));
                        chk({tag, " req_addr"}, o_req_addr, ak);
                        chk({tag, " req_size"}, o_req_size, (sz > PB_LOG) ? PB_LOG : sz);
                        chk({tag, " req_write"}, o_req_write, wr);
                        if (wr) chk({tag, " req_wdata"}, o_req_wdata, exp_wd);
                    end
                    if ($urandom_range(99) < stall_pct) begin
                        stalls++;
                    end else begin
                        ak     = (n == 1) ? a : a + k * PB;
                        base_k = ak & ~(PB - 1);
                        i_ack     = 1'b1;
                        i_ack_err = (k == err_beat);
                        for (int j = 0; j < PB; j++) begin
                            i_ack_rdata[8*j +: 8] = mem[(base_k + j) % 4096];
                            exp_rd[8*((base_k % AB) + j) +: 8] = mem[(base_k + j) % 4096];
                        end
                        k++;
                    end
                end else begin
                    // Ack lines are don't-care while no beat is requested
                    i_ack     = 1'($urandom_range(1));
                    i_ack_err = 1'($urandom_range(1));
                end
                @(negedge HCLK);
            end
        end

        exp_waits = illegal ? 1 : ((wr ? 1 : 0) + n_issue + stalls + (beat_err ? 1 : 0));
        chk({tag, " completes"}, done, 1);
        chk({tag, " wait_states"}, waits, exp_waits);
        chk({tag, " beats"}, k, n_issue);
        chk({tag, " err1_seen"}, saw_err1, (illegal || beat_err));
        chk({tag, " hresp"}, o_HRESP, (illegal || beat_err));
        if (!illegal && !beat_err && !wr) model_hrdata = exp_rd;
        chk({tag, " hrdata"}, o_HRDATA, model_hrdata);
        $display("xfer %-14s addr=%08h size=%0d wr=%0d waits=%0d beats=%0d hresp=%0d hrdata=%08h",
                 tag, a, sz, wr, waits, k, o_HRESP, o_HRDATA);
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rsz;
        int          rerr;

        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h100] = 8'h11;
        mem[12'h101] = 8'h22;
        mem[12'h102] = 8'h33;
        mem[12'h103] = 8'h44;
        model_hrdata = '0;

        HRESET      = 1'b1;
        i_HSEL      = 1'b0;
        i_HADDR     = '0;
        i_HTRANS    = 2'd0;
        i_HWRITE    = 1'b0;
        i_HSIZE     = 3'd0;
        i_HWDATA    = '0;
        i_HREADY    = 1'b1;
        i_ack       = 1'b0;
        i_ack_rdata = '0;
        i_ack_err   = 1'b0;

        // Reset state
        repeat (2) @(negedge HCLK);
        chk("rst hreadyout", o_HREADYOUT, 1);
        chk("rst hresp", o_HRESP, 0);
        chk("rst hrdata", o_HRDATA, 0);
        chk("rst req", o_req, 0);
        chk("rst req_addr", o_req_addr, 0);
        chk("rst req_size", o_req_size, 0);
        chk("rst req_wdata", o_req_wdata, 0);
        chk("rst req_write", o_req_write, 0);
        HRESET = 1'b0;
        @(negedge HCLK);
        $display("reset released hreadyout=%0d req=%0d", o_HREADYOUT, o_req);

        // Split word read, immediate acks
        xfer("split_rd", 32'h100, 3'd2, 1'b0, 32'h0, -1, 0);
        chk("split_rd value", o_HRDATA, 32'h4433_2211);

        // Single-beat byte write to the top lane
        xfer("byte_wr", 32'h203, 3'd0, 1'b1, 32'hAB00_0000, -1, 0);

        // Illegal transfers; the second one and a read are presented in ERR2
        xfer("misalign_h", 32'h101, 3'd1, 1'b0, 32'h0, -1, 0);
        xfer("size3", 32'h0, 3'd3, 1'b0, 32'h0, -1, 0);
        xfer("err2_pipe_rd", 32'h100, 3'd2, 1'b0, 32'h0, -1, 0);

        // Backend error on the third beat of a split write
        xfer("mid_err_wr", 32'h300, 3'd2, 1'b1, 32'hDDCC_BBAA, 2, 0);
        @(negedge HCLK);

        // BUSY transfers are not accepted
        for (int i = 0; i < 3; i++) begin
            i_HSEL   = 1'b1;
            i_HTRANS = 2'd1;
            i_HADDR  = 32'h100;
            @(negedge HCLK);
            chk("busy req", o_req, 0);
            chk("busy hreadyout", o_HREADYOUT, 1);
            $display("busy cycle %0d req=%0d hreadyout=%0d", i, o_req, o_HREADYOUT);
        end
        i_HSEL   = 1'b0;
        i_HTRANS = 2'd0;

        // Reset during beat 0 of a split read
        i_HSEL   = 1'b1;
        i_HTRANS = 2'd2;
        i_HADDR  = 32'h100;
        i_HSIZE  = 3'd2;
        i_HWRITE = 1'b0;
        @(negedge HCLK);
        i_HSEL   = 1'b0;
        i_HTRANS = 2'd0;
        chk("midrst req_before", o_req, 1);
        HRESET      = 1'b1;
        i_ack       = 1'b1;
        i_ack_rdata = 8'h99;
        @(negedge HCLK);
        HRESET = 1'b0;
        i_ack  = 1'b0;
        model_hrdata = '0;
        chk("midrst req", o_req, 0);
        chk("midrst hreadyout", o_HREADYOUT, 1);
        chk("midrst hresp", o_HRESP, 0);
        chk("midrst hrdata", o_HRDATA, 0);
        $display("mid-transfer reset req=%0d hrdata=%08h", o_req, o_HRDATA);
        xfer("post_rst_rd", 32'h100, 3'd2, 1'b0, 32'h0, -1, 0);
        chk("post_rst_rd value", o_HRDATA, 32'h4433_2211);

        // Randomized transfers with backend stalls and errors
        for (int t = 0; t < 60; t++) begin
            rsz = 3'($urandom_range(3));
            ra  = $urandom_range(4088);
            if ($urandom_range(4) != 0) ra = ra & ~((32'd1 << rsz) - 1);
            rerr = ($urandom_range(5) == 0) ? int'($urandom_range(3)) : -1;
            xfer("rand", ra, rsz, 1'($urandom_range(1)), $urandom, rerr, 30);
            if ($urandom_range(1) == 1) @(negedge HCLK);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
